bsg_manycore_store_credit_ctrl: RTL and testbench



---
 rtl/bsg_manycore_store_credit_ctrl_if.sv | 20 ++
 rtl/bsg_manycore_store_credit_ctrl.sv | 51 +++++
 tb/tb_bsg_manycore_store_credit_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_store_credit_ctrl_if.sv
// bsg_manycore_store_credit_ctrl_if: store issue, return, fence and freeze handshake signals
interface bsg_manycore_store_credit_ctrl_if;
    logic freeze_i;
    logic req_v_i;
    logic req_ready_o;
    logic out_v_o;
    logic out_ready_i;
    logic ret_v_i;
    logic ret_ready_o;
    logic fence_v_i;
    logic fence_yumi_o;
    modport master (
        output freeze_i, req_v_i, out_ready_i, ret_v_i, fence_v_i,
        input  req_ready_o, out_v_o, ret_ready_o, fence_yumi_o
    );
    modport slave (
        input  freeze_i, req_v_i, out_ready_i, ret_v_i, fence_v_i,
        output req_ready_o, out_v_o, ret_ready_o, fence_yumi_o
    );
endinterface

// File: rtl/bsg_manycore_store_credit_ctrl.sv
// bsg_manycore_store_credit_ctrl: credit-gates remote stores, counts acks, drains on fence
module bsg_manycore_store_credit_ctrl #(
    parameter int max_out_p = 16,
    parameter int perf_width_p = 16,
    localparam int cntr_width_lp = $clog2(max_out_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_manycore_store_credit_ctrl_if.slave bus,
    output logic [cntr_width_lp-1:0] out_cnt_o,
    output logic [perf_width_p-1:0]  fence_cycles_o,
    output logic                     err_o
);
    typedef enum logic [1:0] {idle_s, drain_s, done_s} state_e;
    state_e state_r, state_n;
    logic [cntr_width_lp-1:0] cnt_r, cnt_n;
    logic allow, issue, underflow;
    // Credit check uses the registered count, so a same-cycle return frees a slot only next cycle
    always_comb begin
        allow = (state_r == idle_s) & ~bus.fence_v_i & ~bus.freeze_i & (cnt_r < cntr_width_lp'(max_out_p));
        bus.out_v_o = bus.req_v_i & allow;
        bus.req_ready_o = allow & bus.out_ready_i;
        bus.ret_ready_o = 1'b1;
        bus.fence_yumi_o = state_r == done_s;
        issue = bus.out_v_o & bus.out_ready_i;
        underflow = bus.ret_v_i & ~issue & (cnt_r == '0);
        cnt_n = (issue & ~bus.ret_v_i) ? cnt_r + cntr_width_lp'(1)
              : (bus.ret_v_i & ~issue & (cnt_r != '0)) ? cnt_r - cntr_width_lp'(1)
              : cnt_r;
        state_n = (state_r == idle_s) ? (bus.fence_v_i ? ((cnt_r == '0) ? done_s : drain_s) : idle_s)
                : (state_r == drain_s) ? ((cnt_n == '0) ? done_s : drain_s)
                : idle_s;
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= idle_s;
            cnt_r <= '0;
            err_o <= 1'b0;
            fence_cycles_o <= '0;
        end else begin
            state_r <= state_n;
            cnt_r <= cnt_n;
            err_o <= err_o | underflow;
            if (state_r == drain_s && ~&fence_cycles_o)
                fence_cycles_o <= fence_cycles_o + perf_width_p'(1);
        end
    end
    assign out_cnt_o = cnt_r;
    a_out_v_needs_req: assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.out_v_o |-> bus.req_v_i);
    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i) cnt_r <= cntr_width_lp'(max_out_p));
endmodule

// File: tb/tb_bsg_manycore_store_credit_ctrl.sv
// tb_bsg_manycore_store_credit_ctrl: directed + random checks against a credit/fence model
`timescale 1ns/1ps
module tb_bsg_manycore_store_credit_ctrl;
    localparam int max_lp = 4;
    localparam int pw_lp = 4;
    localparam int cw_lp = $clog2(max_lp + 1);
    localparam int psat_lp = (1 << pw_lp) - 1;
    logic clk_i = 1'b0;
    logic reset_n_i;
    logic [cw_lp-1:0] out_cnt;
    logic [pw_lp-1:0] fcyc;
    logic err;
    int tests = 0;
    int fails = 0;
    bsg_manycore_store_credit_ctrl_if bus();
    bsg_manycore_store_credit_ctrl #(.max_out_p(max_lp), .perf_width_p(pw_lp)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus),
        .out_cnt_o(out_cnt), .fence_cycles_o(fcyc), .err_o(err)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: outstanding count is max(0, count + issued - returned);
    // a fence is "open" from acceptance until its yumi cycle ends
    int m_cnt, m_perf, sum, n_cnt;
    logic m_err, m_open, m_yumi, n_open, n_yumi, n_under;
    logic e_allow, e_out_v, e_ready, e_issue;
    always_comb begin
        e_allow = !m_open && !bus.fence_v_i && !bus.freeze_i && m_cnt < max_lp;
        e_out_v = bus.req_v_i && e_allow;
        e_ready = e_allow && bus.out_ready_i;
        e_issue = e_out_v && bus.out_ready_i;
        sum = m_cnt + int'(e_issue) - int'(bus.ret_v_i);
        n_cnt = sum < 0 ? 0 : sum;
        n_under = sum < 0;
        n_yumi = (m_open && !m_yumi) ? (n_cnt == 0) : (!m_open && bus.fence_v_i && m_cnt == 0);
        n_open = m_yumi ? 1'b0 : (m_open || bus.fence_v_i);
    end
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_cnt <= 0;
            m_perf <= 0;
            m_err <= 1'b0;
            m_open <= 1'b0;
            m_yumi <= 1'b0;
        end else begin
            m_cnt <= n_cnt;
            m_err <= m_err | n_under;
            m_perf <= (m_open && !m_yumi && m_perf < psat_lp) ? m_perf + 1 : m_perf;
            m_open <= n_open;
            m_yumi <= n_yumi;
        end
    end
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            chk("req_ready", bus.req_ready_o, e_ready);
            chk("out_v", bus.out_v_o, e_out_v);
            chk("ret_ready", bus.ret_ready_o, 1);
            chk("fence_yumi", bus.fence_yumi_o, m_yumi);
            chk("out_cnt", out_cnt, m_cnt);
            chk("fence_cycles", fcyc, m_perf);
            chk("err", err, m_err);
            if (m_open) chk("fence_held", bus.fence_v_i, 1);
        end
    end
    task automatic cyc(input logic rv, input logic ordy, input logic ret, input logic fv, input logic frz);
        @(posedge clk_i);
        #1;
        bus.req_v_i = rv;
        bus.out_ready_i = ordy;
        bus.ret_v_i = ret;
        bus.fence_v_i = fv;
        bus.freeze_i = frz;
        @(negedge clk_i);
    endtask
    initial begin
        logic fv, y;
        reset_n_i = 1'b0;
        bus.req_v_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.ret_v_i = 1'b0;
        bus.fence_v_i = 1'b0;
        bus.freeze_i = 1'b0;
        #12;
        chk("rst_cnt", out_cnt, 0);
        chk("rst_fcyc", fcyc, 0);
        chk("rst_err", err, 0);
        chk("rst_yumi", bus.fence_yumi_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) begin
            cyc(1, 1, 0, 0, 0);
            chk("b2b_ready", bus.req_ready_o, 1);
        end
        cyc(0, 1, 0, 0, 0);
        chk("b2b_cnt3", out_cnt, 3);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("full_cnt", out_cnt, 4);
        chk("full_blocked", bus.req_ready_o, 0);
        cyc(1, 1, 1, 0, 0);
        chk("full_ret_blocked", bus.req_ready_o, 0);
        cyc(1, 1, 0, 0, 0);
        chk("full_cnt3", out_cnt, 3);
        chk("full_reissue", bus.req_ready_o, 1);
        cyc(0, 1, 0, 0, 0);
        chk("full_cnt4", out_cnt, 4);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("both_pre", out_cnt, 2);
        cyc(0, 1, 0, 0, 0);
        chk("both_cnt", out_cnt, 2);
        chk("both_err", err, 0);
        repeat (3) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("uflow_cnt", out_cnt, 0);
        chk("uflow_err", err, 1);
        cyc(0, 1, 0, 0, 0);
        chk("uflow_sticky", err, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        chk("fence_cnt2", out_cnt, 2);
        chk("fence_no_issue", bus.out_v_o, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        chk("fence_early_yumi", bus.fence_yumi_o, 0);
        chk("fence_drain_issue", bus.out_v_o, 0);
        cyc(0, 1, 0, 1, 0);
        chk("fence_yumi", bus.fence_yumi_o, 1);
        chk("fence_cycles6", fcyc, 6);
        cyc(0, 1, 0, 0, 0);
        chk("fence_yumi_pulse", bus.fence_yumi_o, 0);
        chk("fence_cnt0", out_cnt, 0);
        cyc(0, 1, 0, 1, 0);
        chk("empty_fence_pre", bus.fence_yumi_o, 0);
        cyc(0, 1, 0, 1, 0);
        chk("empty_fence_yumi", bus.fence_yumi_o, 1);
        chk("empty_fence_cycles", fcyc, 6);
        cyc(0, 1, 0, 0, 0);
        chk("empty_fence_done", bus.fence_yumi_o, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        repeat (19) cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 1, 0);
        chk("sat_yumi", bus.fence_yumi_o, 1);
        chk("sat_cycles", fcyc, psat_lp);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_cnt", out_cnt, 0);
        chk("arst_fcyc", fcyc, 0);
        chk("arst_err", err, 0);
        chk("arst_yumi", bus.fence_yumi_o, 0);
        bus.fence_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) begin
            cyc(0, 1, 0, 0, 0);
            chk("arst_no_yumi", bus.fence_yumi_o, 0);
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        chk("frz_out_v", bus.out_v_o, 0);
        chk("frz_ready", bus.req_ready_o, 0);
        cyc(1, 1, 1, 0, 1);
        cyc(1, 1, 1, 0, 1);
        chk("frz_cnt1", out_cnt, 1);
        cyc(0, 1, 0, 0, 1);
        chk("frz_cnt0", out_cnt, 0);
        fv = 1'b0;
        y = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (fv && y) fv = 1'b0;
            else if (!fv && $urandom_range(19) == 0) fv = 1'b1;
            cyc($urandom_range(9) < 6, $urandom_range(9) < 8, $urandom_range(9) < 4, fv, $urandom_range(9) == 0);
            y = bus.fence_yumi_o;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
